// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU encodings, FSM states and instruction field positions
package cpu_pkg;
    localparam logic [3:0] OP_LAST_ALU = 4'd5;
    localparam logic [3:0] OP_ADDI     = 4'd6;
    localparam logic [3:0] OP_LI       = 4'd7;
    localparam logic [3:0] OP_JMP      = 4'd8;
    localparam logic [3:0] OP_BEQZ     = 4'd9;
    localparam logic [3:0] OP_HALT     = 4'd15;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_SLT    = 3'd5;
    localparam logic [2:0] ALU_PASS_A = 3'd6;
    localparam logic [2:0] ALU_PASS_B = 3'd7;

    localparam int OP_LSB = 12;
    localparam int RC_LSB = 8;
    localparam int RA_LSB = 4;
    localparam int RB_LSB = 0;
    localparam int IMM_W  = 8;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;
endpackage

// File: rtl/decodificador_instr.sv
// decodificador_instr: combinational instruction decode into bank, ALU and control fields
module decodificador_instr
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  regA,
    output logic [3:0]  regB,
    output logic [3:0]  regC,
    output logic [15:0] imediato,
    output logic        flagImediato,
    output logic [2:0]  alu_op,
    output logic        we,
    output logic        jmp,
    output logic        br,
    output logic        halt
);
    logic [3:0] op;
    logic [3:0] rc;

    always_comb begin
        op           = ir[OP_LSB +: 4];
        rc           = ir[RC_LSB +: 4];
        regA         = ir[RA_LSB +: 4];
        // ADDI and BEQZ read rc through the B port
        regB         = (op == OP_ADDI || op == OP_BEQZ) ? rc : ir[RB_LSB +: 4];
        regC         = rc;
        imediato     = {{(16-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
        flagImediato = op == OP_ADDI || op == OP_LI;
        alu_op       = op <= OP_LAST_ALU ? op[2:0] :
                       op == OP_LI       ? ALU_PASS_A :
                       op == OP_BEQZ     ? ALU_PASS_B : ALU_ADD;
        we           = op <= OP_LI;
        jmp          = op == OP_JMP;
        br           = op == OP_BEQZ;
        halt         = op == OP_HALT;
    end
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning the PC
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic [15:0]     alu_res,
    input  logic            alu_zero,
    output logic [3:0]      regA,
    output logic [3:0]      regB,
    output logic [3:0]      regC,
    output logic            RW,
    output logic [15:0]     imediato,
    output logic            flagImediato,
    output logic [15:0]     dado,
    output logic [2:0]      alu_op,
    output logic            halted
);
    state_t      state;
    logic [15:0] ir;
    logic [15:0] dec_in;
    logic        zero;
    logic        we;
    logic        jmp;
    logic        br;
    logic        halt;

    // the bank samples operands at the end of DECODE, before IR is loaded
    assign dec_in = state == S_DECODE ? instr : ir;

    decodificador_instr u_dec (
        .ir           (dec_in),
        .regA         (regA),
        .regB         (regB),
        .regC         (regC),
        .imediato     (imediato),
        .flagImediato (flagImediato),
        .alu_op       (alu_op),
        .we           (we),
        .jmp          (jmp),
        .br           (br),
        .halt         (halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= '0;
            ir     <= '0;
            dado   <= '0;
            zero   <= 1'b0;
            RW     <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH:   state <= S_DECODE;
                S_DECODE: begin
                    ir    <= instr;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    dado  <= alu_res;
                    zero  <= alu_zero;
                    RW    <= we;
                    state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    RW     <= 1'b0;
                    pc     <= halt ? pc : (jmp || (br && zero)) ? PC_W'(ir[IMM_W-1:0]) : pc + PC_W'(1);
                    halted <= halt;
                    state  <= halt ? S_HALT : S_FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed vectors, reset/halt sequences and random programs vs an ISA-level model
module tb_unidade_controle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc;
    logic [15:0] instr = 16'h0;
    logic [15:0] alu_res;
    logic        alu_zero;
    logic [3:0]  regA, regB, regC;
    logic        RW;
    logic [15:0] imediato;
    logic        flagImediato;
    logic [15:0] dado;
    logic [2:0]  alu_op;
    logic        halted;

    logic [15:0] mem [256];
    logic [15:0] bank [16] = '{default: '0};
    logic [15:0] a_q = 16'h0, b_q = 16'h0;
    int          wcount = 0;
    int          tests = 0, fails = 0;

    logic [15:0] mr [16];
    logic [7:0]  mpc;

    typedef struct {
        int          addr;
        logic [15:0] w;
        int we, rc, dd, npc, ra, rb, fi, aop, imm;
    } vec_t;
    vec_t tv [11];

    unidade_controle #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .alu_res(alu_res), .alu_zero(alu_zero),
        .regA(regA), .regB(regB), .regC(regC), .RW(RW), .imediato(imediato),
        .flagImediato(flagImediato), .dado(dado), .alu_op(alu_op), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return {15'h0, $signed(a) < $signed(b)};
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    // environment: registered instruction memory, register bank and ALU
    always @(posedge clk) begin
        instr <= mem[pc];
        if (RW) begin
            bank[regC] <= dado;
            wcount     <= wcount + 1;
        end else begin
            a_q <= flagImediato ? imediato : bank[regA];
            b_q <= bank[regB];
        end
    end
    assign alu_res  = alu(alu_op, a_q, b_q);
    assign alu_zero = alu_res == 16'h0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // entered at a negedge inside FETCH, leaves at the negedge of the next FETCH
    task automatic do_instr(input string nm, input int addr, input int we, input int rc, input int dd,
                            input int npc, input int ra, input int rb, input int fi, input int aop, input int imm);
        int rwc;
        chk({nm, " fetch pc"}, pc, addr);
        rwc = RW;
        @(negedge clk);
        rwc += RW;
        chk({nm, " decode RW"}, RW, 0);
        if (ra >= 0) chk({nm, " regA"}, regA, ra);
        if (rb >= 0) chk({nm, " regB"}, regB, rb);
        if (fi >= 0) chk({nm, " flagImediato"}, flagImediato, fi);
        if (imm >= 0) chk({nm, " imediato"}, imediato, imm);
        @(negedge clk);
        rwc += RW;
        if (aop >= 0) chk({nm, " alu_op"}, alu_op, aop);
        @(negedge clk);
        rwc += RW;
        chk({nm, " wb halted"}, halted, 0);
        if (we != 0) begin
            chk({nm, " regC"}, regC, rc);
            chk({nm, " dado"}, dado, dd);
        end
        @(negedge clk);
        chk({nm, " RW pulses"}, rwc, we);
        chk({nm, " next pc"}, pc, npc);
    endtask

    // instruction-level reference: architectural registers and PC
    task automatic model_step(input logic [15:0] w, output int we, output int rc, output int dd, output int npc,
                              output int ra, output int rb, output int fi, output int aop);
        logic [3:0]  op;
        logic [15:0] imm, res;
        logic [7:0]  p1;
        op  = w[15:12];
        imm = {{8{w[7]}}, w[7:0]};
        res = 16'h0;
        p1  = mpc + 8'd1;
        rc = w[11:8]; we = 0; dd = 0; npc = p1; ra = -1; rb = -1; fi = -1; aop = -1;
        if (op <= 4'd5) begin
            res = alu(op[2:0], mr[w[7:4]], mr[w[3:0]]);
            we = 1; ra = w[7:4]; rb = w[3:0]; fi = 0; aop = op;
        end else if (op == 4'd6) begin
            res = imm + mr[w[11:8]];
            we = 1; rb = rc; fi = 1; aop = 0;
        end else if (op == 4'd7) begin
            res = imm;
            we = 1; fi = 1; aop = 6;
        end else if (op == 4'd8) begin
            npc = w[7:0];
        end else if (op == 4'd9) begin
            rb = rc; aop = 7;
            if (mr[w[11:8]] == 16'h0) npc = w[7:0];
        end
        if (we != 0) begin
            mr[w[11:8]] = res;
            dd = res;
        end
        mpc = npc[7:0];
    endtask

    initial begin
        int w0;
        logic [15:0] w;
        int we, rc, dd, npc, ra, rb, fi, aop;

        tv[0]  = '{8'h00, 16'h7105, 1, 1, 16'h0005, 8'h01, -1, -1, 1, 6, 16'h0005};
        tv[1]  = '{8'h01, 16'h61FF, 1, 1, 16'h0004, 8'h02, -1,  1, 1, 0, 16'hFFFF};
        tv[2]  = '{8'h02, 16'h7203, 1, 2, 16'h0003, 8'h03, -1, -1, 1, 6, -1};
        tv[3]  = '{8'h03, 16'h1312, 1, 3, 16'h0001, 8'h04,  1,  2, 0, 1, -1};
        tv[4]  = '{8'h04, 16'h9420, 0, 0, 0,        8'h20, -1,  4, -1, 7, -1};
        tv[5]  = '{8'h20, 16'h9120, 0, 0, 0,        8'h21, -1,  1, -1, 7, -1};
        tv[6]  = '{8'h21, 16'h0512, 1, 5, 16'h0007, 8'h22,  1,  2, 0, 0, -1};
        tv[7]  = '{8'h22, 16'h5612, 1, 6, 16'h0000, 8'h23,  1,  2, 0, 5, -1};
        tv[8]  = '{8'h23, 16'h4712, 1, 7, 16'h0007, 8'h24,  1,  2, 0, 4, -1};
        tv[9]  = '{8'h24, 16'h88FF, 0, 0, 0,        8'hFF, -1, -1, -1, -1, -1};
        tv[10] = '{8'hFF, 16'hA000, 0, 0, 0,        8'h00, -1, -1, -1, -1, -1};

        @(negedge clk);
        chk("reset pc", pc, 0);
        chk("reset RW", RW, 0);
        chk("reset regA", regA, 0);
        chk("reset regB", regB, 0);
        chk("reset regC", regC, 0);
        chk("reset imediato", imediato, 0);
        chk("reset flagImediato", flagImediato, 0);
        chk("reset dado", dado, 0);
        chk("reset alu_op", alu_op, 0);
        chk("reset halted", halted, 0);

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int k = 0; k < 11; k++) mem[tv[k].addr] = tv[k].w;
        do_reset();
        for (int k = 0; k < 11; k++)
            do_instr($sformatf("vec%0d", k), tv[k].addr, tv[k].we, tv[k].rc, tv[k].dd, tv[k].npc,
                     tv[k].ra, tv[k].rb, tv[k].fi, tv[k].aop, tv[k].imm);
        chk("no halt after table", halted, 0);

        // reset asserted in the middle of an LI write-back
        mem[0] = 16'h7105;
        do_reset();
        repeat (3) @(negedge clk);
        chk("midwb RW before reset", RW, 1);
        w0 = wcount;
        #1 rst_n = 1'b0;
        #1;
        chk("midwb RW async drop", RW, 0);
        chk("midwb pc", pc, 0);
        @(posedge clk);
        #1;
        chk("midwb no bank write", wcount, w0);
        chk("midwb pc after edge", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_instr("midwb refetch", 0, 1, 1, 5, 1, -1, -1, 1, 6, 5);

        // HALT freezes pc and stays halted
        mem[1] = 16'hF000;
        do_reset();
        do_instr("halt li", 0, 1, 1, 5, 1, -1, -1, 1, 6, 5);
        do_instr("halt", 1, 0, 0, 0, 1, -1, -1, -1, -1, -1);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("halted c%0d", c), halted, 1);
            chk($sformatf("halt pc c%0d", c), pc, 1);
            chk($sformatf("halt RW c%0d", c), RW, 0);
            @(negedge clk);
        end

        // random programs without HALT
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hF) w[15:12] = 4'hA;
                mem[i] = w;
            end
            rst_n = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 16; i++) mr[i] = bank[i];
            mpc = 8'h0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 50; n++) begin
                int a;
                a = mpc;
                w = mem[mpc];
                model_step(w, we, rc, dd, npc, ra, rb, fi, aop);
                do_instr($sformatf("rnd%0d.%0d op%0h", r, n, w[15:12]), a, we, rc, dd, npc, ra, rb, fi, aop,
                         (fi == 1) ? int'({{8{w[7]}}, w[7:0]}) : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
